br_update_queue: RTL and testbench
==================================

Name: br_update_queue

Overview:
In-flight branch tracking queue between fetch/predict and branch resolution, directly upstream of the predictor's update port.
- Records each issued prediction (index plus predicted direction) in program order.
- On each in-order resolution, pops the oldest entry and drives a one-cycle update (update enable, index, outcome, correct flag) into the predictor wrapper.
- Keeps optional accuracy statistics.

Parameters:
DEPTH, 8, number of in-flight entries; power of two, >= 2
IDX_W, 32, width of the predictor index
CNT_W, 32, width of the statistics counters

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
pred_valid_i  input  1  a prediction was issued this cycle
pred_idx_i  input  IDX_W  predictor index of the issued branch
pred_taken_i  input  1  predicted direction (1 = taken)
pred_ready_o  output  1  queue can accept a prediction
res_valid_i  input  1  oldest branch resolved this cycle
res_taken_i  input  1  actual direction
res_ready_o  output  1  queue holds an entry to resolve
flush_i  input  1  discard all in-flight entries
upd_en_o  output  1  predictor update strobe
upd_idx_o  output  IDX_W  index to update
upd_br_result_o  output  1  actual outcome to train with
upd_correct_o  output  1  prediction matched outcome
count_o  output  $clog2(DEPTH)+1  current occupancy
branch_cnt_o  output  CNT_W  resolved branches (statistics)
mispredict_cnt_o  output  CNT_W  mispredicted branches (statistics)

Behaviour:
Reset (rst_i = 1 at clock edge):
- All outputs 0 after the edge, except pred_ready_o = 1.
- Pointers, occupancy and counters cleared.
- Entry storage need not be cleared.
- rst_i overrides every other input, including a push or resolve in the same cycle.

Ready signals:
- pred_ready_o = (count_o != DEPTH), combinational from registered state.
- res_ready_o = (count_o != 0), combinational from registered state.

Push:
- Occurs when pred_valid_i && pred_ready_o.
- Writes {pred_idx_i, pred_taken_i} at the tail; tail increments modulo DEPTH.
- pred_valid_i while full is ignored; no overwrite.

Pop:
- Occurs when res_valid_i && res_ready_o; reads the head entry, head increments modulo DEPTH.
- Next cycle (1-cycle latency, registered outputs): upd_en_o = 1, upd_idx_o = head idx, upd_br_result_o = res_taken_i, upd_correct_o = (res_taken_i == head pred).
- upd_en_o is a single-cycle pulse per pop. Back-to-back pops give consecutive pulses.
- When upd_en_o = 0, the other upd_* outputs hold their last values.

Simultaneous and boundary events:
- Push and pop in the same cycle: both happen, count unchanged.
- When full, a push is refused even if a pop happens that cycle (no same-cycle slot reuse).
- When empty, a resolve is refused even if a push happens that cycle (no bypass).
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. Full/empty is decided by count_o, never by pointer equality.

Flush:
- Any cycle with flush_i = 1: next cycle count_o = 0 and head = tail.
- A push or pop in the flush cycle is discarded and produces no update pulse.
- An update pulse already registered from the previous cycle still appears.
- Flushed entries never generate updates.

Statistics:
- On each pop, branch_cnt_o increments; mispredict_cnt_o also increments if the prediction was incorrect.
- Both counters saturate at all-ones.
- Counters are not cleared by flush_i, only by rst_i.

Optional Feature:
Macro BUQ_STATS_EN.
- Defined: branch_cnt_o and mispredict_cnt_o behave as in Statistics.
- Not defined: no counter registers are built; both outputs are constant 0.
- Queue and update behaviour are identical in both builds.

Test Plan:
1. Reset then three pushes (idx 0x10 taken, 0x20 not, 0x30 taken) then three resolves with outcomes 1, 1, 0 -> upd_en_o pulses on 3 consecutive cycles, each one cycle after its resolve. Values: idx 0x10/0x20/0x30, br_result 1/1/0, correct 1/0/0. With BUQ_STATS_EN: branch_cnt 3, mispredict_cnt 2.
2. Push DEPTH=8 entries -> count_o 8, pred_ready_o 0. A 9th push with a simultaneous resolve -> 9th push dropped, count_o 7. The next push is accepted.
3. Empty queue, pred_valid_i and res_valid_i together -> res_ready_o 0, no update pulse, count_o 1. Resolving next cycle -> update for that entry.
4. Wrap-around: 20 interleaved push/pop pairs with alternating idx -> updates emerge in exact push order across pointer wrap, count_o never exceeds 1.
5. Four entries queued, resolve in cycle N and flush_i in cycle N+1 -> one update pulse at N+1, count_o 0 at N+2, further resolves refused, no more pulses.
6. rst_i asserted mid-stream with 5 entries and a resolve the same cycle -> no update pulse; next cycle count_o 0, pred_ready_o 1, res_ready_o 0, counters 0.

Source files
------------

// File: rtl/br_update_queue.sv
// In-flight branch queue that pops in order on resolution and drives a registered predictor update.
// Optional accuracy counters are built only when BUQ_STATS_EN is defined.
module br_update_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned IDX_W = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     pred_valid_i,
    input  logic [IDX_W-1:0]         pred_idx_i,
    input  logic                     pred_taken_i,
    output logic                     pred_ready_o,
    input  logic                     res_valid_i,
    input  logic                     res_taken_i,
    output logic                     res_ready_o,
    input  logic                     flush_i,
    output logic                     upd_en_o,
    output logic [IDX_W-1:0]         upd_idx_o,
    output logic                     upd_br_result_o,
    output logic                     upd_correct_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [CNT_W-1:0]         branch_cnt_o,
    output logic [CNT_W-1:0]         mispredict_cnt_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [IDX_W-1:0] idx_mem [DEPTH];
    logic [DEPTH-1:0] taken_mem;

    logic [PTR_W-1:0] head_q, tail_q;
    logic [PTR_W:0]   count_q;
    logic             upd_en_q, upd_br_result_q, upd_correct_q;
    logic [IDX_W-1:0] upd_idx_q;

    logic push, pop, head_correct;

    assign pred_ready_o = (count_q != FULL_CNT);
    assign res_ready_o  = (count_q != '0);

    // Flush discards any push or pop in the same cycle.
    assign push         = pred_valid_i && pred_ready_o && !flush_i;
    assign pop          = res_valid_i && res_ready_o && !flush_i;
    assign head_correct = (res_taken_i == taken_mem[head_q]);

    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            idx_mem[tail_q]   <= pred_idx_i;
            taken_mem[tail_q] <= pred_taken_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            upd_en_q        <= 1'b0;
            upd_idx_q       <= '0;
            upd_br_result_q <= 1'b0;
            upd_correct_q   <= 1'b0;
        end else begin
            upd_en_q <= pop;
            if (flush_i) begin
                head_q  <= tail_q;
                count_q <= '0;
            end else begin
                if (push) tail_q <= tail_q + 1'b1;
                if (pop) head_q <= head_q + 1'b1;
                if (push && !pop) count_q <= count_q + 1'b1;
                else if (pop && !push) count_q <= count_q - 1'b1;
            end
            if (pop) begin
                upd_idx_q       <= idx_mem[head_q];
                upd_br_result_q <= res_taken_i;
                upd_correct_q   <= head_correct;
            end
        end
    end

    assign upd_en_o        = upd_en_q;
    assign upd_idx_o       = upd_idx_q;
    assign upd_br_result_o = upd_br_result_q;
    assign upd_correct_o   = upd_correct_q;
    assign count_o         = count_q;

`ifdef BUQ_STATS_EN
    logic [CNT_W-1:0] branch_cnt_q, mispredict_cnt_q;

    // Both counters saturate; flush leaves them untouched.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else if (pop) begin
            if (branch_cnt_q != '1) branch_cnt_q <= branch_cnt_q + 1'b1;
            if (!head_correct && mispredict_cnt_q != '1) begin
                mispredict_cnt_q <= mispredict_cnt_q + 1'b1;
            end
        end
    end

    assign branch_cnt_o     = branch_cnt_q;
    assign mispredict_cnt_o = mispredict_cnt_q;
`else
    assign branch_cnt_o     = '0;
    assign mispredict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_br_update_queue.sv
// Scoreboard bench for br_update_queue: the driver queues expected updates, a monitor checks each pulse.
module tb_br_update_queue;

    localparam int DEPTH = 8;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        pred_valid_i = 1'b0;
    logic [31:0] pred_idx_i = '0;
    logic        pred_taken_i = 1'b0;
    logic        pred_ready_o;
    logic        res_valid_i = 1'b0;
    logic        res_taken_i = 1'b0;
    logic        res_ready_o;
    logic        flush_i = 1'b0;
    logic        upd_en_o;
    logic [31:0] upd_idx_o;
    logic        upd_br_result_o;
    logic        upd_correct_o;
    logic [3:0]  count_o;
    logic [31:0] branch_cnt_o;
    logic [31:0] mispredict_cnt_o;

    br_update_queue #(.DEPTH(DEPTH), .IDX_W(32), .CNT_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .pred_valid_i(pred_valid_i), .pred_idx_i(pred_idx_i), .pred_taken_i(pred_taken_i),
        .pred_ready_o(pred_ready_o),
        .res_valid_i(res_valid_i), .res_taken_i(res_taken_i), .res_ready_o(res_ready_o),
        .flush_i(flush_i),
        .upd_en_o(upd_en_o), .upd_idx_o(upd_idx_o), .upd_br_result_o(upd_br_result_o),
        .upd_correct_o(upd_correct_o), .count_o(count_o),
        .branch_cnt_o(branch_cnt_o), .mispredict_cnt_o(mispredict_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int          cyc;
        logic [31:0] idx;
        logic        res;
        logic        cor;
    } exp_t;

    typedef struct {
        logic [31:0] idx;
        logic        taken;
    } ent_t;

    exp_t sb[$];
    ent_t model[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    int unsigned mbr = 0;
    int unsigned mmis = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every pulse must match the oldest expectation and arrive in its cycle.
    always @(negedge clk_i) begin
        if (mon_en) begin
            if (upd_en_o) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_update: got idx 0x%0h at cycle %0d, none expected",
                             upd_idx_o, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.cyc != cyc || upd_idx_o !== e.idx || upd_br_result_o !== e.res ||
                        upd_correct_o !== e.cor) begin
                        errors++;
                        $display("FAIL update: got cyc=%0d idx=0x%0h res=%0b cor=%0b expected cyc=%0d idx=0x%0h res=%0b cor=%0b",
                                 cyc, upd_idx_o, upd_br_result_o, upd_correct_o,
                                 e.cyc, e.idx, e.res, e.cor);
                    end
                end
            end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                exp_t e;
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_update: no pulse at cycle %0d, expected idx 0x%0h", cyc, e.idx);
            end
        end
    end

    task automatic step(input logic r, input logic pv, input logic [31:0] pi, input logic pt,
                        input logic rv, input logic rt, input logic fl);
        bit push_ok, pop_ok;
        rst_i = r; pred_valid_i = pv; pred_idx_i = pi; pred_taken_i = pt;
        res_valid_i = rv; res_taken_i = rt; flush_i = fl;
        if (r) begin
            model.delete();
            mbr = 0;
            mmis = 0;
        end else if (fl) begin
            model.delete();
        end else begin
            push_ok = pv && (model.size() != DEPTH);
            pop_ok  = rv && (model.size() != 0);
            if (pop_ok) begin
                ent_t e;
                e = model.pop_front();
                sb.push_back('{cyc: cyc + 1, idx: e.idx, res: rt, cor: (rt == e.taken)});
                mbr++;
                if (rt != e.taken) mmis++;
            end
            if (push_ok) model.push_back('{idx: pi, taken: pt});
        end
        @(posedge clk_i);
        #1;
        rst_i = 0; pred_valid_i = 0; res_valid_i = 0; flush_i = 0;
    endtask

    task automatic push(input logic [31:0] idx, input logic t);
        step(0, 1, idx, t, 0, 0, 0);
    endtask

    task automatic resolve(input logic t);
        step(0, 0, 0, 0, 1, t, 0);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_stats(input string name);
`ifdef BUQ_STATS_EN
        chk({name, "_branch_cnt"}, 64'(branch_cnt_o), 64'(mbr));
        chk({name, "_mispredict_cnt"}, 64'(mispredict_cnt_o), 64'(mmis));
`else
        chk({name, "_branch_cnt"}, 64'(branch_cnt_o), 64'd0);
        chk({name, "_mispredict_cnt"}, 64'(mispredict_cnt_o), 64'd0);
`endif
    endtask

    initial begin
        @(posedge clk_i);
        #1;
        step(1, 0, 0, 0, 0, 0, 0);
        mon_en = 1'b1;
        chk("reset_count", 64'(count_o), 64'd0);
        chk("reset_pred_ready", 64'(pred_ready_o), 64'd1);
        chk("reset_res_ready", 64'(res_ready_o), 64'd0);
        chk("reset_upd_en", 64'(upd_en_o), 64'd0);
        chk("reset_upd_idx", 64'(upd_idx_o), 64'd0);
        chk_stats("reset");

        // Test 1: basic in-order resolution.
        push(32'h10, 1); push(32'h20, 0); push(32'h30, 1);
        chk("t1_count3", 64'(count_o), 64'd3);
        resolve(1); resolve(1); resolve(0);
        idle();
        chk("t1_count0", 64'(count_o), 64'd0);
        chk("t1_hold_idx", 64'(upd_idx_o), 64'h30);
`ifdef BUQ_STATS_EN
        chk("t1_branch_cnt", 64'(branch_cnt_o), 64'd3);
        chk("t1_mispredict_cnt", 64'(mispredict_cnt_o), 64'd2);
`else
        chk_stats("t1");
`endif

        // Test 2: full queue refuses a push even with a simultaneous pop.
        for (int i = 0; i < DEPTH; i++) push(32'h100 + i, i[0]);
        chk("t2_count_full", 64'(count_o), 64'd8);
        chk("t2_pred_ready_full", 64'(pred_ready_o), 64'd0);
        step(0, 1, 32'h1FF, 1, 1, 1, 0);
        chk("t2_count_after_drop", 64'(count_o), 64'd7);
        push(32'h200, 0);
        chk("t2_count_refill", 64'(count_o), 64'd8);
        for (int i = 0; i < DEPTH; i++) resolve(i[1]);
        idle();
        chk("t2_count_drained", 64'(count_o), 64'd0);

        // Test 3: no bypass from push to resolve on an empty queue.
        rst_i = 0;
        chk("t3_res_ready_empty", 64'(res_ready_o), 64'd0);
        step(0, 1, 32'h40, 1, 1, 0, 0);
        chk("t3_count1", 64'(count_o), 64'd1);
        resolve(0);
        idle();

        // Test 4: interleaved pairs across pointer wrap.
        for (int i = 0; i < 20; i++) begin
            push((i % 2 == 0) ? (32'hAA00 + i) : (32'h5500 + i), i[0]);
            chk("t4_count_push", 64'(count_o), 64'd1);
            resolve(i[1]);
            chk("t4_count_pop", 64'(count_o), 64'd0);
        end
        idle();

        // Test 5: flush one cycle after a resolve.
        for (int i = 0; i < 4; i++) push(32'h300 + i, 1);
        resolve(1);
        step(0, 1, 32'h3FF, 0, 1, 0, 1);
        chk("t5_count_flushed", 64'(count_o), 64'd0);
        chk("t5_res_ready", 64'(res_ready_o), 64'd0);
        resolve(1);
        idle(); idle();
        chk_stats("t5");

        // Test 6: reset mid-stream overrides a resolve.
        for (int i = 0; i < 5; i++) push(32'h400 + i, 0);
        step(1, 1, 32'h4FF, 1, 1, 1, 0);
        chk("t6_count", 64'(count_o), 64'd0);
        chk("t6_pred_ready", 64'(pred_ready_o), 64'd1);
        chk("t6_res_ready", 64'(res_ready_o), 64'd0);
        chk("t6_upd_en", 64'(upd_en_o), 64'd0);
        chk_stats("t6");
        idle(); idle();

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
